regfile_param: RTL
==================

// Module: regfile_param
// PURPOSE
//  Parametrised multi-port register file; successor to the single-bit enable flop array in the regfile.
//  Generalises width, depth and read-port count, and adds per-byte write strobes.
//  Adds a hard-wired zero register, optional write-to-read bypass and optional registered (1-cycle) reads.
//  Sits between decode (read addresses) and writeback (write port) of the processor datapath.
// PARAMETERS
//  DATA_W   32  data width in bits; must be a multiple of 8
//  ADDR_W   5   address width; DEPTH = 2**ADDR_W registers
//  NREAD    2   number of independent read ports (1..4)
//  ZERO_R0  1   1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary
//  BYPASS   1   1: same-cycle write data forwarded to matching read; 0: reads see old value
//  READ_REG 0   0: combinational read (latency 0); 1: registered read (latency 1)
// PORTS
//  clk        in   1              rising-edge clock
//  clr        in   1              synchronous active-high reset
//  we         in   1              write enable
//  wstrb      in   DATA_W/8       byte write strobes; bit i covers wdata[8i+7:8i]
//  waddr      in   ADDR_W         write address
//  wdata      in   DATA_W         write data
//  raddr      in   NREAD*ADDR_W   packed read addresses; port k = raddr[k*ADDR_W +: ADDR_W]
//  rdata      out  NREAD*DATA_W   packed read data; port k = rdata[k*DATA_W +: DATA_W]
//  rvalid     out  NREAD          per port: rdata valid (always 1 when READ_REG=0)
// BEHAVIOUR
//  - Reset: clr sampled at posedge clk.
//    - All registers <= 0; rdata output regs (READ_REG=1) <= 0; rvalid <= 0.
//    - clr has priority over a same-cycle write; the write is dropped.
//  - Write: at posedge clk with we=1 && !clr, each byte i with wstrb[i]=1 is updated from wdata. Other bytes hold.
//    - we=1 with wstrb=0 is a no-op.
//    - ZERO_R0=1 and waddr=0: write ignored.
//  - Read, READ_REG=0:
//    - rdata[k] = mem[raddr[k]] combinationally.
//    - rvalid = all ones, including during clr; data reads 0 after reset.
//  - Read, READ_REG=1:
//    - rdata[k] registered at posedge from the address presented in the previous cycle.
//    - rvalid[k] = 1 from the first cycle after clr deasserts.
//  - Bypass (BYPASS=1): if we && !clr && waddr==raddr[k] (and not the zero register):
//    - Strobed bytes read wdata; unstrobed bytes read the stored value. Merge is per byte.
//    - With READ_REG=1 the merged value is captured into the output register.
//  - BYPASS=0: read of the address being written returns the pre-write value.
//  - ZERO_R0=1: raddr[k]==0 always returns 0, regardless of bypass.
//  - Multiple read ports may address the same register; each returns identical data.
//  - No X: out-of-range cannot occur (DEPTH = 2**ADDR_W). Initial contents undefined until first clr.
// STRUCTURE
//  - Shared package regfile_pkg:
//    - localparams: BYTE_W=8, DEFAULT_DATA_W, DEFAULT_ADDR_W
//    - function byte_merge(old, new, strb) used by both write and bypass paths
//  - One sub-module dffe_sync #(W): W-bit register with d, en, sync clr, q.
//    - Instantiated once per byte lane per register, with en = we & decode & wstrb[i].
//    - Also used for read output regs when READ_REG=1.
//  - Read muxes and bypass compare via generate loop over NREAD.
// TESTING
//  1 Reset: write 0xDEADBEEF to r5, assert clr 1 cycle -> read r5 = 0x00000000; (READ_REG=1) rvalid=0 during clr, 1 after.
//  2 Byte strobes: r3=0x11223344, write 0xAABBCCDD wstrb=4'b0101 -> r3 reads 0x11BB33DD.
//  3 Zero reg (ZERO_R0=1): write 0xFFFFFFFF to r0 -> all ports read r0 = 0; with ZERO_R0=0 -> reads 0xFFFFFFFF.
//  4 Bypass: r7=0x0, same cycle we=1 waddr=7 wdata=0x12345678 wstrb=4'b1111, raddr0=7
//    - BYPASS=1 -> rdata0=0x12345678 that cycle
//    - BYPASS=0 -> 0x0 that cycle, 0x12345678 next.
//  5 clr+write collision: clr=1, we=1 waddr=9 wdata=0x55 -> r9 reads 0 afterwards.
//  6 Multi-port, READ_REG=1, NREAD=3: raddr={r2,r2,r4} with r2=0xA, r4=0xB -> one cycle later rdata={0xA,0xA,0xB}.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and the byte-merge helper used by the register file.
package regfile_pkg;

  localparam int BYTE_W         = 8;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  // Upper bound for the merge helper; narrower callers zero-extend in and truncate out.
  localparam int MAX_DATA_W = 128;
  localparam int MAX_STRB_W = MAX_DATA_W / BYTE_W;

  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_v,
    input logic [MAX_DATA_W-1:0] new_v,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] m;
    m = old_v;
    for (int i = 0; i < MAX_STRB_W; i++) begin
      if (strb[i]) m[i*BYTE_W +: BYTE_W] = new_v[i*BYTE_W +: BYTE_W];
    end
    return m;
  endfunction

endpackage

// File: rtl/regfile_param_dffe_sync.sv
// W-bit enabled register with synchronous clear; clear wins over enable.
module dffe_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-port register file with byte strobes, optional zero
// register, optional write-to-read bypass and optional registered reads.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NREAD    = 2,
  parameter int ZERO_R0  = 1,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    we,
  input  logic [DATA_W/8-1:0]     wstrb,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  output logic [NREAD-1:0]        rvalid
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int STRB_W = DATA_W / BYTE_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  // Storage: one enabled byte lane per register; register 0 is tied off when hard-wired to zero.
  for (genvar r = 0; r < DEPTH; r++) begin : g_reg
    if (ZERO_R0 != 0 && r == 0) begin : g_zero
      assign mem[r] = '0;
    end else begin : g_store
      for (genvar i = 0; i < STRB_W; i++) begin : g_lane
        dffe_sync #(.W(BYTE_W)) u_lane (
          .clk (clk),
          .clr (clr),
          .en  (we && (waddr == ADDR_W'(r)) && wstrb[i]),
          .d   (wdata[i*BYTE_W +: BYTE_W]),
          .q   (mem[r][i*BYTE_W +: BYTE_W])
        );
      end
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_next;
    logic              is_zero;
    logic              hit;

    assign ra      = raddr[k*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_R0 != 0) && (ra == '0);
    assign hit     = (BYPASS != 0) && we && !clr && (waddr == ra) && !is_zero;

    // Zero register overrides bypass, bypass overrides the stored word.
    always_comb begin
      rd_next = mem[ra];
      if (hit) rd_next = DATA_W'(byte_merge(MAX_DATA_W'(mem[ra]), MAX_DATA_W'(wdata),
                                            MAX_STRB_W'(wstrb)));
      if (is_zero) rd_next = '0;
    end

    if (READ_REG != 0) begin : g_reg_out
      dffe_sync #(.W(DATA_W)) u_rdata (
        .clk (clk),
        .clr (clr),
        .en  (1'b1),
        .d   (rd_next),
        .q   (rdata[k*DATA_W +: DATA_W])
      );
      dffe_sync #(.W(1)) u_rvalid (
        .clk (clk),
        .clr (clr),
        .en  (1'b1),
        .d   (1'b1),
        .q   (rvalid[k])
      );
    end else begin : g_comb_out
      assign rdata[k*DATA_W +: DATA_W] = rd_next;
      assign rvalid[k]                 = 1'b1;
    end
  end

endmodule
